// File: rtl/rspm_pkg.sv
// Shared constants for the stored-program datapath: ALU opcodes and Bus 2 select codes.
package rspm_pkg;

    localparam int OP_NOP = 0;
    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_AND = 3;
    localparam int OP_NOT = 4;

    typedef enum logic [1:0] {
        BUS2_ALU  = 2'd0,
        BUS2_BUS1 = 2'd1,
        BUS2_MEM  = 2'd2,
        BUS2_ZERO = 2'd3
    } bus2_sel_e;

endpackage

// File: rtl/alu_gen.sv
// Parametrised ALU: operand A is the Y register, operand B is Bus 1.
module alu_gen
    import rspm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 4
) (
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              negative
);

    logic [DATA_W:0] sum;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        sum    = {1'b0, a} + {1'b0, b};
        case (opcode)
            OPC_W'(OP_ADD): begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            // Subtraction is B minus Y; carry reports a borrow.
            OPC_W'(OP_SUB): begin
                result = b - a;
                carry  = (b < a);
            end
            OPC_W'(OP_AND): result = a & b;
            OPC_W'(OP_NOT): result = ~b;
            default: result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign negative = result[DATA_W-1];

endmodule

// File: rtl/return_stack.sv
// Hardware return-address LIFO with occupancy status and a sticky misuse flag.
module return_stack #(
    parameter int DATA_W   = 8,
    parameter int RS_DEPTH = 4,
    parameter int DEP_W    = $clog2(RS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic              pop_ok,
    output logic [DEP_W-1:0]  depth,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [DATA_W-1:0] stack_mem [RS_DEPTH];
    logic [DEP_W-1:0]  depth_q, depth_d;
    logic              err_q, err_d;
    logic              push_ok;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    always_comb begin
        full    = (depth_q == DEP_W'(RS_DEPTH));
        empty   = (depth_q == '0);
        // Simultaneous push and pop is treated as misuse and changes nothing.
        push_ok = push & ~pop & ~full;
        pop_ok  = pop & ~push & ~empty;
        wr_idx  = IDX_W'(depth_q);
        rd_idx  = IDX_W'(depth_q - DEP_W'(1));
        depth_d = depth_q;
        if (push_ok) begin
            depth_d = depth_q + DEP_W'(1);
        end else if (pop_ok) begin
            depth_d = depth_q - DEP_W'(1);
        end
        err_d = err_q | (push & pop) | (push & full) | (pop & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Entry storage is deliberately left unreset; depth alone defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_mem[wr_idx] <= push_data;
        end
    end

    assign top_data = stack_mem[rd_idx];
    assign depth    = depth_q;
    assign err      = err_q;

endmodule

// File: rtl/processing_unit_gen.sv
// Generic-width datapath: register file, Y/IR/address/PC registers, ZCN flags and return stack.
module processing_unit_gen
    import rspm_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int RS_DEPTH = 4,
    parameter int OPC_W    = 4,
    localparam int SEL1_W  = $clog2(NUM_REGS + 1),
    localparam int DEP_W   = $clog2(RS_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   mem_word,
    input  logic [SEL1_W-1:0]   sel_bus_1,
    input  logic [1:0]          sel_bus_2,
    input  logic [NUM_REGS-1:0] load_reg,
    input  logic                load_pc,
    input  logic                inc_pc,
    input  logic                load_ir,
    input  logic                load_add_r,
    input  logic                load_reg_y,
    input  logic                load_flags,
    input  logic                push_ret,
    input  logic                pop_ret,
    output logic [DATA_W-1:0]   instruction,
    output logic [DATA_W-1:0]   address,
    output logic [DATA_W-1:0]   bus_1,
    output logic                zflag,
    output logic                cflag,
    output logic                nflag,
    output logic [DEP_W-1:0]    rs_depth,
    output logic                rs_full,
    output logic                rs_empty,
    output logic                rs_err
);

    logic [DATA_W-1:0] reg_q [NUM_REGS];
    logic [DATA_W-1:0] reg_d [NUM_REGS];
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              z_q, z_d, c_q, c_d, n_q, n_d;

    logic [DATA_W-1:0] bus_2;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry, alu_zero, alu_neg;
    logic [DATA_W-1:0] rs_top;
    logic              rs_pop_ok;

    alu_gen #(.DATA_W(DATA_W), .OPC_W(OPC_W)) u_alu (
        .opcode   (ir_q[DATA_W-1 -: OPC_W]),
        .a        (y_q),
        .b        (bus_1),
        .result   (alu_result),
        .carry    (alu_carry),
        .zero     (alu_zero),
        .negative (alu_neg)
    );

    return_stack #(.DATA_W(DATA_W), .RS_DEPTH(RS_DEPTH), .DEP_W(DEP_W)) u_rs (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ret),
        .pop       (pop_ret),
        .push_data (pc_q),
        .top_data  (rs_top),
        .pop_ok    (rs_pop_ok),
        .depth     (rs_depth),
        .full      (rs_full),
        .empty     (rs_empty),
        .err       (rs_err)
    );

    // Bus 1: register index, then PC, with unused codes reading as zero.
    always_comb begin
        bus_1 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_bus_1 == SEL1_W'(i)) begin
                bus_1 = reg_q[i];
            end
        end
        if (sel_bus_1 == SEL1_W'(NUM_REGS)) begin
            bus_1 = pc_q;
        end
    end

    always_comb begin
        case (sel_bus_2)
            BUS2_ALU:  bus_2 = alu_result;
            BUS2_BUS1: bus_2 = bus_1;
            BUS2_MEM:  bus_2 = mem_word;
            default:   bus_2 = '0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_d[i] = load_reg[i] ? bus_2 : reg_q[i];
        end
        y_d    = load_reg_y ? bus_2 : y_q;
        ir_d   = load_ir    ? bus_2 : ir_q;
        addr_d = load_add_r ? bus_2 : addr_q;
        // A successful pop outranks explicit loads and increments.
        pc_d = pc_q;
        if (rs_pop_ok) begin
            pc_d = rs_top;
        end else if (load_pc) begin
            pc_d = bus_2;
        end else if (inc_pc) begin
            pc_d = pc_q + DATA_W'(1);
        end
        z_d = load_flags ? alu_zero  : z_q;
        c_d = load_flags ? alu_carry : c_q;
        n_d = load_flags ? alu_neg   : n_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= '0;
            end
            y_q    <= '0;
            ir_q   <= '0;
            addr_q <= '0;
            pc_q   <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            n_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= reg_d[i];
            end
            y_q    <= y_d;
            ir_q   <= ir_d;
            addr_q <= addr_d;
            pc_q   <= pc_d;
            z_q    <= z_d;
            c_q    <= c_d;
            n_q    <= n_d;
        end
    end

    assign instruction = ir_q;
    assign address     = addr_q;
    assign zflag       = z_q;
    assign cflag       = c_q;
    assign nflag       = n_q;

endmodule

// File: tb/tb_processing_unit_gen.sv
// Directed plus randomised bench for processing_unit_gen with a scoreboard queue of expected values.
module tb_processing_unit_gen;

    localparam logic [2:0] SEL_PC = 3'd4;
    localparam logic [1:0] B2_ALU = 2'd0, B2_BUS1 = 2'd1, B2_MEM = 2'd2, B2_ZERO = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem_word = '0;
    logic [2:0] sel_bus_1 = '0;
    logic [1:0] sel_bus_2 = '0;
    logic [3:0] load_reg = '0;
    logic       load_pc = 0, inc_pc = 0, load_ir = 0, load_add_r = 0;
    logic       load_reg_y = 0, load_flags = 0, push_ret = 0, pop_ret = 0;
    logic [7:0] instruction, address, bus_1;
    logic       zflag, cflag, nflag;
    logic [2:0] rs_depth;
    logic       rs_full, rs_empty, rs_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    processing_unit_gen dut (
        .clk(clk), .rst(rst), .mem_word(mem_word), .sel_bus_1(sel_bus_1), .sel_bus_2(sel_bus_2),
        .load_reg(load_reg), .load_pc(load_pc), .inc_pc(inc_pc), .load_ir(load_ir),
        .load_add_r(load_add_r), .load_reg_y(load_reg_y), .load_flags(load_flags),
        .push_ret(push_ret), .pop_ret(pop_ret), .instruction(instruction), .address(address),
        .bus_1(bus_1), .zflag(zflag), .cflag(cflag), .nflag(nflag), .rs_depth(rs_depth),
        .rs_full(rs_full), .rs_empty(rs_empty), .rs_err(rs_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        load_reg = '0; load_pc = 0; inc_pc = 0; load_ir = 0; load_add_r = 0;
        load_reg_y = 0; load_flags = 0; push_ret = 0; pop_ret = 0;
        sel_bus_2 = B2_ZERO;
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed %0h expected <scoreboard empty>", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic load_from_mem(input logic [7:0] v, input int target);
        clear_strobes();
        mem_word  = v;
        sel_bus_2 = B2_MEM;
        case (target)
            0, 1, 2, 3: load_reg[target] = 1'b1;
            4: load_reg_y = 1;
            5: load_ir = 1;
            default: load_pc = 1;
        endcase
        tick();
        clear_strobes();
    endtask

    // Reference ALU: returns {z, c, n, result}.
    function automatic logic [10:0] alu_model(input logic [3:0] op, input logic [7:0] y, input logic [7:0] b);
        logic [7:0] r;
        logic       c;
        int         s;
        r = 8'h00;
        c = 1'b0;
        case (op)
            4'd1: begin s = int'(y) + int'(b); r = s[7:0]; c = (s > 255); end
            4'd2: begin r = b - y; c = (b < y); end
            4'd3: r = y & b;
            4'd4: r = ~b;
            default: r = 8'h00;
        endcase
        return {(r == 8'h00), c, r[7], r};
    endfunction

    initial begin
        logic [10:0] m;
        logic [7:0]  ry, rb;
        logic [3:0]  rop;

        // Reset state, observed while reset is still asserted.
        #3;
        sel_bus_1 = SEL_PC;
        #1;
        expect_val(0); check("rst_ir", instruction);
        expect_val(0); check("rst_addr", address);
        expect_val(0); check("rst_pc", bus_1);
        expect_val(0); check("rst_flags", {zflag, cflag, nflag});
        expect_val(0); check("rst_depth", rs_depth);
        expect_val(1); check("rst_empty", rs_empty);
        expect_val(0); check("rst_full", rs_full);
        expect_val(0); check("rst_err", rs_err);
        @(posedge clk); #1;
        rst = 0;
        clear_strobes();

        // PC increment and wrap.
        inc_pc = 1;
        expect_val(8'hFF);
        repeat (255) tick();
        check("pc_inc_255", bus_1);
        expect_val(8'h00);
        tick();
        check("pc_wrap", bus_1);
        clear_strobes();

        // SUB: B=R1=5, Y=7 -> 0xFE, borrow and negative.
        load_from_mem(8'h05, 1);
        load_from_mem(8'h07, 4);
        load_from_mem(8'h20, 5);
        expect_val(8'h20); check("ir_load", instruction);
        sel_bus_1 = 3'd1;
        #1;
        expect_val(8'h05); check("bus1_r1", bus_1);
        sel_bus_2 = B2_ALU; load_add_r = 1; load_flags = 1;
        expect_val(8'hFE); expect_val(3'b011);
        tick();
        check("sub_result", address);
        check("sub_flags_zcn", {zflag, cflag, nflag});
        clear_strobes();

        // ADD: 0xFF + 0x01 wraps to zero with carry.
        load_from_mem(8'hFF, 4);
        load_from_mem(8'h01, 1);
        load_from_mem(8'h10, 5);
        sel_bus_1 = 3'd1; sel_bus_2 = B2_ALU; load_add_r = 1; load_flags = 1;
        expect_val(8'h00); expect_val(3'b110);
        tick();
        check("add_result", address);
        check("add_flags_zcn", {zflag, cflag, nflag});
        clear_strobes();

        // AND without load_flags: flags must hold.
        load_from_mem(8'h30, 5);
        sel_bus_1 = 3'd1; sel_bus_2 = B2_ALU; load_add_r = 1;
        expect_val(8'h01); expect_val(3'b110);
        tick();
        check("and_result", address);
        check("flags_hold", {zflag, cflag, nflag});
        clear_strobes();

        // Bus 2 from Bus 1 into two registers at once, and the zero source.
        sel_bus_1 = 3'd1; sel_bus_2 = B2_BUS1; load_reg = 4'b1001;
        tick();
        clear_strobes();
        sel_bus_1 = 3'd3; #1;
        expect_val(8'h01); check("bus2_bus1_r3", bus_1);
        sel_bus_1 = 3'd0; #1;
        expect_val(8'h01); check("bus2_bus1_r0", bus_1);
        sel_bus_1 = 3'd7; #1;
        expect_val(8'h00); check("bus1_unused_code", bus_1);
        sel_bus_2 = B2_ZERO; load_add_r = 1;
        expect_val(8'h00);
        tick();
        check("bus2_zero", address);
        clear_strobes();

        // Randomised ALU operations against the reference model.
        for (int i = 0; i < 8; i++) begin
            ry  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 4'($urandom_range(0, 6));
            load_from_mem(ry, 4);
            load_from_mem(rb, 2);
            load_from_mem({rop, 4'h0}, 5);
            sel_bus_1 = 3'd2; sel_bus_2 = B2_ALU; load_add_r = 1; load_flags = 1;
            m = alu_model(rop, ry, rb);
            expect_val(m[7:0]); expect_val(m[10:8]);
            tick();
            check("rand_result", address);
            check("rand_flags_zcn", {zflag, cflag, nflag});
            clear_strobes();
        end

        // Return stack fill, overflow and unwind.
        load_from_mem(8'h10, 6);
        sel_bus_1 = SEL_PC;
        for (int i = 1; i <= 4; i++) begin
            push_ret = 1; inc_pc = 1;
            expect_val(i);
            tick();
            check("push_depth", rs_depth);
        end
        clear_strobes();
        expect_val(1); check("full_after_4", rs_full);
        expect_val(0); check("err_before_overflow", rs_err);
        push_ret = 1;
        expect_val(1); expect_val(4); expect_val(8'h14);
        tick();
        check("overflow_err", rs_err);
        check("overflow_depth", rs_depth);
        check("overflow_pc", bus_1);
        clear_strobes();
        for (int i = 0; i < 4; i++) begin
            pop_ret = 1;
            expect_val(8'h13 - i);
            tick();
            check("pop_pc", bus_1);
        end
        clear_strobes();
        expect_val(1); check("empty_after_pops", rs_empty);
        expect_val(1); check("err_sticky", rs_err);
        #2 rst = 1;
        #2 rst = 0;
        expect_val(0); check("err_cleared_by_rst", rs_err);

        // Pop on empty stack: PC follows inc_pc.
        load_from_mem(8'h20, 6);
        pop_ret = 1; inc_pc = 1;
        expect_val(8'h21); expect_val(1); expect_val(0);
        tick();
        check("pop_empty_pc", bus_1);
        check("pop_empty_err", rs_err);
        check("pop_empty_depth", rs_depth);
        clear_strobes();

        // Simultaneous push and pop.
        #2 rst = 1;
        #2 rst = 0;
        load_from_mem(8'h50, 6);
        push_ret = 1;
        tick();
        clear_strobes();
        push_ret = 1; pop_ret = 1; inc_pc = 1;
        expect_val(1); expect_val(1); expect_val(8'h51);
        tick();
        check("push_pop_depth", rs_depth);
        check("push_pop_err", rs_err);
        check("push_pop_pc", bus_1);
        clear_strobes();
        pop_ret = 1;
        expect_val(8'h50);
        tick();
        check("push_pop_top_intact", bus_1);
        clear_strobes();

        // Asynchronous reset between edges while a push is pending.
        #2 rst = 1;
        #2 rst = 0;
        load_from_mem(8'h30, 6);
        push_ret = 1; inc_pc = 1;
        tick(); tick();
        clear_strobes();
        expect_val(2); check("pre_reset_depth", rs_depth);
        push_ret = 1;
        #2 rst = 1;
        #1;
        expect_val(0); check("async_rst_depth", rs_depth);
        expect_val(0); check("async_rst_pc", bus_1);
        expect_val(1); check("async_rst_empty", rs_empty);
        @(posedge clk); #1;
        expect_val(0); check("rst_discards_push", rs_depth);
        rst = 0;
        clear_strobes();

        // Normal stack operation after reset.
        load_from_mem(8'h40, 6);
        push_ret = 1; inc_pc = 1;
        tick(); tick();
        clear_strobes();
        expect_val(2); check("post_rst_depth", rs_depth);
        pop_ret = 1;
        expect_val(8'h41);
        tick();
        check("post_rst_pop1", bus_1);
        expect_val(8'h40);
        tick();
        check("post_rst_pop2", bus_1);
        clear_strobes();
        expect_val(0); check("post_rst_err", rs_err);
        expect_val(1); check("post_rst_empty", rs_empty);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
